// File: rtl/mul_iter_radix_if.sv
// ---------------------------------------------------------------------------
// mul_iter_radix_if
// Request/response bundle for the iterative multiplier functional unit.
//   flush      : kill in-flight operation and any held response (to unit)
//   req_valid  : request valid (to unit)
//   req_ready  : unit can accept a request (from unit)
//   a, b       : multiplicand / multiplier operands (to unit)
//   mul_type   : 11/00 uu, 01 ss, 10 su (to unit)
//   req_tag    : tag captured with the request (to unit)
//   resp_valid : product valid (from unit)
//   resp_ready : consumer accepts the product (to unit)
//   p          : full 2*WIDTH product (from unit)
//   resp_tag   : tag of the product (from unit)
// master = issuing side (reservation station / CDB), slave = multiplier.
// ---------------------------------------------------------------------------
interface mul_iter_radix_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic               flush;
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [1:0]         mul_type;
  logic [TAG_W-1:0]   req_tag;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*WIDTH-1:0] p;
  logic [TAG_W-1:0]   resp_tag;

  modport master (
    output flush, req_valid, a, b, mul_type, req_tag, resp_ready,
    input  req_ready, resp_valid, p, resp_tag
  );

  modport slave (
    input  flush, req_valid, a, b, mul_type, req_tag, resp_ready,
    output req_ready, resp_valid, p, resp_tag
  );
endinterface

// File: rtl/mul_iter_radix.sv
// ---------------------------------------------------------------------------
// mul_iter_radix
// Iterative sign-magnitude shift-add multiplier (MUL/MULH/MULHSU/MULHU).
// Retires BITS_PER_CYCLE multiplier bits per clock; zero operands finish in
// one cycle.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mul_iter_radix_if.slave (handshakes, operands, tag, flush, product)
// Parameters: WIDTH (multiple of BITS_PER_CYCLE), BITS_PER_CYCLE (1/2/4/8),
// TAG_W. The interface instance must use the same WIDTH and TAG_W.
// ---------------------------------------------------------------------------
module mul_iter_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TAG_W          = 6
) (
  input logic             clk,
  input logic             rst,
  mul_iter_radix_if.slave bus
);
  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [2*WIDTH-1:0] mcand_reg;    // |a|, pre-shifted to the current offset
  logic [WIDTH-1:0]   mplier_reg;   // |b|, consumed from the LSB end
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic               neg_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [TAG_W-1:0]   resp_tag_reg;

  // Operand decode. Negating the most-negative value yields 2^(WIDTH-1),
  // which is still the correct unsigned magnitude.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             op_zero, accept, last_iter;

  always_comb begin
    a_neg   = ((bus.mul_type == 2'b01) || (bus.mul_type == 2'b10)) && bus.a[WIDTH-1];
    b_neg   = (bus.mul_type == 2'b01) && bus.b[WIDTH-1];
    a_mag   = a_neg ? -bus.a : bus.a;
    b_mag   = b_neg ? -bus.b : bus.b;
    op_zero = (bus.a == '0) || (bus.b == '0);
  end

  assign accept    = (state_reg == IDLE) && bus.req_valid && !bus.flush;
  assign last_iter = (cnt_reg == CNT_W'(1));

  // Partial product for this cycle: one shifted copy of |a| per multiplier
  // bit in the current digit, summed below.
  logic [2*WIDTH-1:0] pp_term [BITS_PER_CYCLE];
  logic [2*WIDTH-1:0] pp_sum;
  logic [2*WIDTH-1:0] acc_sum;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp_term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp_sum = pp_sum + pp_term[i];
    end
    acc_sum = acc_reg + pp_sum;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides both accept and the response handshake
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = op_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      acc_reg      <= '0;
      p_reg        <= '0;
      neg_reg      <= 1'b0;
      cnt_reg      <= '0;
      tag_reg      <= '0;
      resp_tag_reg <= '0;
    end else if (accept) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
      mplier_reg <= b_mag;
      acc_reg    <= '0;
      neg_reg    <= a_neg ^ b_neg;
      cnt_reg    <= CNT_W'(ITERS);
      tag_reg    <= bus.req_tag;
      if (op_zero) begin
        // Early-out: the response is complete right away, sign irrelevant
        p_reg        <= '0;
        resp_tag_reg <= bus.req_tag;
      end
    end else if ((state_reg == BUSY) && !bus.flush) begin
      acc_reg    <= acc_sum;
      mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
      mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
      cnt_reg    <= cnt_reg - CNT_W'(1);
      if (last_iter) begin
        // Final digit folds straight into the result latch
        p_reg        <= neg_reg ? -acc_sum : acc_sum;
        resp_tag_reg <= tag_reg;
      end
    end
  end

  // req_ready is gated by rst so it reads 0 while reset is held
  assign bus.req_ready  = (state_reg == IDLE) && !bus.flush && rst;
  assign bus.resp_valid = (state_reg == DONE);
  assign bus.p          = p_reg;
  assign bus.resp_tag   = resp_tag_reg;

endmodule
